// File: rtl/spi_master_pkg.sv
// rtl/spi_master_pkg.sv - shared FSM state type and encodings for the SPI master
package spi_master_pkg;

    typedef logic [1:0] spi_state_t;

    localparam spi_state_t ST_IDLE     = 2'd0;
    localparam spi_state_t ST_SCK_LOW  = 2'd1;
    localparam spi_state_t ST_SCK_HIGH = 2'd2;

endpackage

// File: rtl/spi_master.sv
// rtl/spi_master.sv - byte-wide SPI mode-0 master with inline clock divider
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   clkdiv          SCK half-period in clk cycles (0 behaves as 1), latched per byte
//   spi_sck         SPI clock, idles low (mode 0)
//   spi_mosi        serial data out, MSB first, holds last bit while idle
//   spi_miso        serial data in, sampled on SCK rising edge
//   spi_cs_n        registered chip select, changes only between bytes
//   cs_assert       pulse: drive spi_cs_n low
//   cs_deassert     pulse: drive spi_cs_n high (wins over cs_assert)
//   tx_data_valid   pulse: start a byte transfer with tx_data
//   tx_data         byte to transmit
//   busy            byte transfer in progress
//   rx_data_valid   pulse: rx_data carries a newly received byte
//   rx_data         last received byte
import spi_master_pkg::*;

module spi_master #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] clkdiv,
    output logic                 spi_sck,
    output logic                 spi_mosi,
    input  logic                 spi_miso,
    output logic                 spi_cs_n,
    input  logic                 cs_assert,
    input  logic                 cs_deassert,
    input  logic                 tx_data_valid,
    input  logic [7:0]           tx_data,
    output logic                 busy,
    output logic                 rx_data_valid,
    output logic [7:0]           rx_data
);

    localparam logic [DIV_WIDTH-1:0] DIV_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    spi_state_t           state_q;
    logic [DIV_WIDTH-1:0] half_q;
    logic [DIV_WIDTH-1:0] phase_q;
    logic [2:0]           bit_cnt_q;
    logic [7:0]           shreg_q;
    logic [7:0]           rx_q;
    logic                 sck_q;
    logic                 mosi_q;
    logic                 cs_n_q;

    logic [DIV_WIDTH-1:0] div_eff;
    logic                 half_done;
    logic                 last_fall;
    logic                 ready;
    logic                 accept;

    assign div_eff   = (clkdiv == '0) ? DIV_ONE : clkdiv;
    assign half_done = (phase_q == half_q - DIV_ONE);

    // The cycle whose closing edge is the eighth SCK falling edge already
    // holds the complete received byte, so it doubles as the first cycle in
    // which a new byte (or a chip-select change) may be accepted. This is
    // what lets back-to-back bytes run without stretching SCK low.
    assign last_fall = (state_q == ST_SCK_HIGH) && half_done && (bit_cnt_q == 3'd7);
    assign ready     = (state_q == ST_IDLE) || last_fall;
    assign accept    = ready && tx_data_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            half_q    <= '0;
            phase_q   <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            rx_q      <= '0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
        end else begin
            if (ready) begin
                if (cs_deassert) begin
                    cs_n_q <= 1'b1;
                end else if (cs_assert) begin
                    cs_n_q <= 1'b0;
                end
            end

            if (last_fall) begin
                rx_q <= shreg_q;
            end

            if (accept) begin
                shreg_q   <= tx_data;
                half_q    <= div_eff;
                phase_q   <= '0;
                bit_cnt_q <= '0;
                mosi_q    <= tx_data[7];
                sck_q     <= 1'b0;
                state_q   <= ST_SCK_LOW;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_IDLE;
                    end
                    ST_SCK_LOW: begin
                        if (half_done) begin
                            sck_q   <= 1'b1;
                            phase_q <= '0;
                            shreg_q <= {shreg_q[6:0], spi_miso};
                            state_q <= ST_SCK_HIGH;
                        end else begin
                            phase_q <= phase_q + DIV_ONE;
                        end
                    end
                    ST_SCK_HIGH: begin
                        if (half_done) begin
                            sck_q     <= 1'b0;
                            phase_q   <= '0;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                // mosi keeps bit 0 while idle
                                state_q <= ST_IDLE;
                            end else begin
                                // after the rising-edge shift, bit 7 is the next bit to send
                                mosi_q  <= shreg_q[7];
                                state_q <= ST_SCK_LOW;
                            end
                        end else begin
                            phase_q <= phase_q + DIV_ONE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign spi_sck       = sck_q;
    assign spi_mosi      = mosi_q;
    assign spi_cs_n      = cs_n_q;
    assign busy          = (state_q != ST_IDLE) && !last_fall;
    assign rx_data_valid = last_fall;
    assign rx_data       = last_fall ? shreg_q : rx_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - self-checking bench for spi_master
module tb_spi_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] clkdiv = 16'd2;
    logic        spi_sck, spi_mosi, spi_miso, spi_cs_n;
    logic        cs_assert = 1'b0, cs_deassert = 1'b0;
    logic        tx_data_valid = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        busy, rx_data_valid;
    logic [7:0]  rx_data;
    logic        loopback = 1'b1;
    logic        miso_val = 1'b0;

    assign spi_miso = loopback ? spi_mosi : miso_val;

    spi_master #(.DIV_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .clkdiv(clkdiv),
        .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n),
        .cs_assert(cs_assert), .cs_deassert(cs_deassert),
        .tx_data_valid(tx_data_valid), .tx_data(tx_data),
        .busy(busy), .rx_data_valid(rx_data_valid), .rx_data(rx_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Accepted transfers: accept cycle, half-period, sent byte, expected received byte
    int         xa[$];
    int         xh[$];
    logic [7:0] xd[$];
    logic [7:0] xr[$];
    int         last_a = 0;

    // Observations
    int         rxq[$];
    int         rises = 0;
    logic [7:0] mos_sr = 8'h00;
    logic       prev_sck = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic model_busy();
        int j;
        if (xa.size() == 0) return 1'b0;
        j = cyc - xa[xa.size()-1];
        return (j >= 1) && (j < 16 * xh[xh.size()-1]);
    endfunction

    // Expected outputs for the current cycle from the transfer timeline:
    // cycle a+j after an accept in cycle a, SCK toggles every h cycles
    // starting low, bit k is on mosi during its 2h-cycle slot, and the
    // received byte is announced in cycle a+16h.
    function automatic void model(output logic e_sck, output logic e_mosi, output logic e_busy,
                                  output logic e_rxv, output logic [7:0] e_rxd);
        int idx;
        int j;
        int h;
        logic [7:0] d;
        idx = -1;
        e_sck = 1'b0; e_mosi = 1'b0; e_busy = 1'b0; e_rxv = 1'b0; e_rxd = 8'h00;
        for (int i = xa.size() - 1; i >= 0; i--) begin
            if (xa[i] < cyc) begin
                idx = i;
                break;
            end
        end
        if (idx >= 0) begin
            j = cyc - xa[idx];
            h = xh[idx];
            d = xd[idx];
            if (idx > 0) e_rxd = xr[idx-1];
            if (j <= 16 * h) begin
                e_sck  = (((j - 1) / h) % 2) == 1;
                e_mosi = d[7 - (j - 1) / (2 * h)];
                e_busy = (j < 16 * h);
                e_rxv  = (j == 16 * h);
                if (j == 16 * h) e_rxd = xr[idx];
            end else begin
                e_mosi = d[0];
                e_rxd  = xr[idx];
            end
        end
    endfunction

    always @(negedge clk) begin
        logic e_sck, e_mosi, e_busy, e_rxv;
        logic [7:0] e_rxd;
        if (rst) begin
            e_sck = 1'b0; e_mosi = 1'b0; e_busy = 1'b0; e_rxv = 1'b0; e_rxd = 8'h00;
            chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
        end else begin
            model(e_sck, e_mosi, e_busy, e_rxv, e_rxd);
        end
        chk("sck", 32'(spi_sck), 32'(e_sck));
        chk("mosi", 32'(spi_mosi), 32'(e_mosi));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("rx_valid", 32'(rx_data_valid), 32'(e_rxv));
        chk("rx_data", 32'(rx_data), 32'(e_rxd));
        if (spi_sck && !prev_sck) begin
            rises++;
            mos_sr = {mos_sr[6:0], spi_mosi};
        end
        prev_sck = spi_sck;
        if (rx_data_valid) rxq.push_back(cyc);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] r, input logic ca, input logic cd);
        int h;
        h = (clkdiv == 16'd0) ? 1 : int'(clkdiv);
        tx_data       = d;
        tx_data_valid = 1'b1;
        cs_assert     = ca;
        cs_deassert   = cd;
        if (!model_busy()) begin
            xa.push_back(cyc);
            xh.push_back(h);
            xd.push_back(d);
            xr.push_back(r);
            last_a = cyc;
        end
        step();
        tx_data_valid = 1'b0;
        cs_assert     = 1'b0;
        cs_deassert   = 1'b0;
    endtask

    task automatic pulse_cs(input logic ca, input logic cd);
        cs_assert   = ca;
        cs_deassert = cd;
        step();
        cs_assert   = 1'b0;
        cs_deassert = 1'b0;
    endtask

    initial begin
        int base_rises;
        int base_pulses;
        int highs;
        logic found;

        wait_cycles(3);
        chk("reset_sck", 32'(spi_sck), 32'd0);
        chk("reset_cs_n", 32'(spi_cs_n), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rx_data", 32'(rx_data), 32'h00);
        rst = 1'b0;
        step();

        // Loopback A5 at clkdiv=2
        clkdiv = 16'd2;
        loopback = 1'b1;
        base_rises = rises;
        send(8'hA5, 8'hA5, 1'b0, 1'b0);
        wait_cycles(40);
        chk("a5_latency", 32'(rxq[rxq.size()-1] - last_a), 32'd32);
        chk("a5_rises", 32'(rises - base_rises), 32'd8);
        chk("a5_rx_data", 32'(rx_data), 32'hA5);

        // miso tied high, clkdiv=0 behaves as 1
        loopback = 1'b0;
        miso_val = 1'b1;
        clkdiv   = 16'd0;
        send(8'h3C, 8'hFF, 1'b0, 1'b0);
        wait_cycles(20);
        chk("div0_latency", 32'(rxq[rxq.size()-1] - last_a), 32'd16);
        chk("div0_rx_data", 32'(rx_data), 32'hFF);
        chk("div0_mosi_bits", 32'(mos_sr), 32'h3C);

        // Drop while busy, clkdiv change mid-byte has no effect
        loopback = 1'b1;
        clkdiv   = 16'd2;
        base_pulses = rxq.size();
        send(8'hC3, 8'hC3, 1'b0, 1'b0);
        wait_cycles(5);
        clkdiv = 16'd5;
        send(8'h11, 8'h11, 1'b0, 1'b0);
        wait_cycles(40);
        chk("drop_pulses", 32'(rxq.size() - base_pulses), 32'd1);
        chk("drop_latency", 32'(rxq[rxq.size()-1] - last_a), 32'd32);
        chk("drop_rx_data", 32'(rx_data), 32'hC3);

        // Chip select with a byte, deassert ignored mid-byte
        clkdiv = 16'd1;
        step();
        send(8'h5A, 8'h5A, 1'b1, 1'b0);
        chk("cs_low_with_first_bit", 32'(spi_cs_n), 32'd0);
        chk("first_bit_5a", 32'(spi_mosi), 32'd0);
        wait_cycles(4);
        pulse_cs(1'b0, 1'b1);
        highs = 0;
        for (int k = 0; k < 15; k++) begin
            if (spi_cs_n) highs++;
            step();
        end
        chk("cs_held_mid_byte", 32'(highs), 32'd0);
        pulse_cs(1'b0, 1'b1);
        chk("cs_deassert_idle", 32'(spi_cs_n), 32'd1);
        pulse_cs(1'b1, 1'b0);
        chk("cs_assert_idle", 32'(spi_cs_n), 32'd0);
        pulse_cs(1'b1, 1'b1);
        chk("cs_both_deassert_wins", 32'(spi_cs_n), 32'd1);

        // Reset at the fourth SCK rising edge
        clkdiv = 16'd2;
        base_pulses = rxq.size();
        send(8'hF0, 8'hF0, 1'b1, 1'b0);
        base_rises = rises - 0;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (rises - base_rises >= 4) begin
                found = 1'b1;
                break;
            end
        end
        chk("fourth_rise_seen", 32'(found), 32'd1);
        #1;
        rst = 1'b1;
        xa.delete(); xh.delete(); xd.delete(); xr.delete();
        #1;
        chk("rst_mid_sck", 32'(spi_sck), 32'd0);
        chk("rst_mid_cs_n", 32'(spi_cs_n), 32'd1);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_mosi", 32'(spi_mosi), 32'd0);
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(1);
        chk("rst_no_pulse", 32'(rxq.size() - base_pulses), 32'd0);

        // Back-to-back bytes at clkdiv=3 right after reset
        clkdiv = 16'd3;
        send(8'h01, 8'h01, 1'b0, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (rx_data_valid) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("b2b_first_pulse", 32'(found), 32'd1);
        chk("b2b_first_rx", 32'(rx_data), 32'h01);
        send(8'h80, 8'h80, 1'b0, 1'b0);
        wait_cycles(60);
        chk("b2b_pulses", 32'(rxq.size() - base_pulses), 32'd2);
        if (rxq.size() >= 2)
            chk("b2b_gap", 32'(rxq[rxq.size()-1] - rxq[rxq.size()-2]), 32'd48);
        chk("b2b_second_rx", 32'(rx_data), 32'h80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
